// File: rtl/comma_aligner.sv
// K28.5 word aligner: hunts for a comma, confirms lock over aligned commas, emits aligned code groups.
// Optional LOCKED->HUNT event counter built when COMMA_ALIGNER_REALIGN_CNT_EN is defined.
module comma_aligner #(
  parameter int unsigned LOCK_COMMAS = 3,
  parameter int unsigned LOSS_COUNT  = 4,
  parameter logic [9:0]  COMMA_N     = 10'h0FA,
  parameter logic [9:0]  COMMA_P     = 10'h305
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_en,
  input  logic [9:0] window,
  output logic [9:0] word_out,
  output logic       word_valid,
  output logic       is_comma,
  output logic       locked,
  output logic [7:0] realign_cnt
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam logic [2:0] LOCK_W = 3'(LOCK_COMMAS);
  localparam logic [2:0] LOSS_W = 3'(LOSS_COUNT);

  state_t     state_q;
  logic       fresh_q;
  logic [3:0] phase_q;
  logic [2:0] good_q;
  logic [2:0] miss_q;
  logic [9:0] word_q;
  logic       valid_q;
  logic       comma_q;
  logic       locked_q;

  logic       cd;
  logic [3:0] phase_d;
  logic       boundary;
  logic [2:0] good_d;
  logic [2:0] miss_d;
  logic       loss;

  always_comb begin
    cd       = (window == COMMA_N) || (window == COMMA_P);
    phase_d  = (phase_q == 4'd9) ? '0 : phase_q + 4'd1;
    boundary = (phase_d == '0);
    good_d   = good_q + 3'd1;
    miss_d   = miss_q + 3'd1;
    loss     = fresh_q && (state_q == LOCKED) && !boundary && cd && (miss_d == LOSS_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      fresh_q  <= 1'b0;
      phase_q  <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      comma_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      fresh_q <= bit_en;
      valid_q <= 1'b0;
      comma_q <= 1'b0;
      if (fresh_q) begin
        phase_q <= phase_d;
        case (state_q)
          HUNT: begin
            if (cd) begin
              phase_q <= '0;
              good_q  <= 3'd1;
              if (LOCK_COMMAS == 1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end else begin
                state_q <= CHECK;
              end
            end
          end
          CHECK: begin
            if (cd && boundary) begin
              good_q <= good_d;
              if (good_d == LOCK_W) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end
            end else if (cd) begin
              phase_q <= '0;
              good_q  <= 3'd1;
            end
          end
          LOCKED: begin
            if (boundary) begin
              word_q  <= window;
              valid_q <= 1'b1;
              comma_q <= cd;
              if (cd) miss_q <= '0;
            end else if (cd) begin
              miss_q <= miss_d;
              if (miss_d == LOSS_W) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                good_q   <= '0;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

`ifdef COMMA_ALIGNER_REALIGN_CNT_EN
  logic [7:0] realign_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         realign_q <= '0;
    else if (loss && realign_q != '1)  realign_q <= realign_q + 8'd1;
  end
  assign realign_cnt = realign_q;
`else
  logic unused_loss;
  assign unused_loss = loss;
  assign realign_cnt = '0;
`endif

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign is_comma   = comma_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: upstream shift register, bit-stream driver and a window-index reference model.
module tb_comma_aligner;

  localparam int LOCK = 3;
  localparam int LOSS = 4;
`ifdef COMMA_ALIGNER_REALIGN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_en = 1'b0;
  logic       bit_in = 1'b0;
  logic [9:0] sr;
  logic [9:0] word_out;
  logic       word_valid, is_comma, locked;
  logic [7:0] realign_cnt;

  int checks = 0;
  int failures = 0;

  comma_aligner #(.LOCK_COMMAS(LOCK), .LOSS_COUNT(LOSS),
                  .COMMA_N(10'h0FA), .COMMA_P(10'h305)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .window(sr),
    .word_out(word_out), .word_valid(word_valid), .is_comma(is_comma),
    .locked(locked), .realign_cnt(realign_cnt));

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) sr <= '0;
    else if (bit_en) sr <= {sr[8:0], bit_in};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: windows are numbered; a boundary is any window whose distance
  // from the last alignment anchor is a multiple of ten.
  int m_mode, m_idx, m_anchor, m_good, m_miss, m_cnt;
  logic [9:0] e_word;
  bit e_valid, e_comma, e_locked, m_prev_en;

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_anchor = 0; m_good = 0; m_miss = 0; m_cnt = 0;
    e_word = '0; e_valid = 0; e_comma = 0; e_locked = 0; m_prev_en = 0;
  endtask

  task automatic model_step(input logic [9:0] w);
    bit cd, bnd;
    cd = (w == 10'h0FA) || (w == 10'h305);
    m_idx++;
    bnd = ((m_idx - m_anchor) % 10) == 0;
    if (m_mode == 0) begin
      if (cd) begin
        m_anchor = m_idx; m_good = 1;
        if (LOCK == 1) begin m_mode = 2; e_locked = 1; m_miss = 0; end
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (cd && bnd) begin
        m_good++;
        if (m_good == LOCK) begin m_mode = 2; e_locked = 1; m_miss = 0; end
      end else if (cd) begin
        m_anchor = m_idx; m_good = 1;
      end
    end else begin
      if (bnd) begin
        e_word = w; e_valid = 1; e_comma = cd;
        if (cd) m_miss = 0;
      end else if (cd) begin
        m_miss++;
        if (m_miss == LOSS) begin
          m_mode = 0; e_locked = 0; m_good = 0;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  int bits_cnt, bits_prev, lock_bits, valid_cnt, valid_at_lock, fall_cnt;
  bit lock_seen, prev_locked;
  logic [10:0] got_q[$];
  logic [9:0] w_s;
  bit en_s, rst_s;

  // Single compare process: updates the model from pre-edge inputs, checks just after the edge.
  initial begin
    model_reset();
    bits_cnt = 0; lock_bits = -1; valid_cnt = 0; fall_cnt = 0; lock_seen = 0; prev_locked = 0;
    forever begin
      @(posedge clk);
      w_s = sr; en_s = bit_en; rst_s = reset;
      bits_prev = bits_cnt;
      if (rst_s) begin
        model_reset();
        bits_cnt = 0; lock_seen = 0; lock_bits = -1;
      end else begin
        e_valid = 0; e_comma = 0;
        if (m_prev_en) model_step(w_s);
        m_prev_en = en_s;
        if (en_s) bits_cnt++;
      end
      #1;
      chk("word_out", 32'(word_out), 32'(e_word));
      chk("word_valid", 32'(word_valid), 32'(e_valid));
      chk("is_comma", 32'(is_comma), 32'(e_comma));
      chk("locked", 32'(locked), 32'(e_locked));
      chk("realign_cnt", 32'(realign_cnt), CNT_EN ? 32'(m_cnt) : 32'd0);
      if (!rst_s && locked && !lock_seen) begin
        lock_seen = 1; lock_bits = bits_prev; valid_at_lock = valid_cnt;
      end
      if (prev_locked && !locked && !rst_s) fall_cnt++;
      prev_locked = locked;
      if (word_valid) begin valid_cnt++; got_q.push_back({is_comma, word_out}); end
    end
  end

  task automatic drive_bit(input logic b, input bit gated);
    if (gated)
      while ($urandom_range(0, 99) >= 30) begin @(negedge clk); bit_en = 1'b0; end
    @(negedge clk); bit_en = 1'b1; bit_in = b;
  endtask

  task automatic drive_word(input logic [9:0] w, input int nbits, input bit gated);
    for (int i = 9; i > 9 - nbits; i--) drive_bit(w[i], gated);
  endtask

  task automatic idle(input int n);
    @(negedge clk); bit_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); bit_en = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [9:0] pat [3];
  int base, vc0;
  logic [9:0] w;

  initial begin
    pat[0] = 10'h0FA; pat[1] = 10'h2AA; pat[2] = 10'h305;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    repeat (50) @(negedge clk);
    chk("idle_locked", 32'(locked), 32'd0);
    chk("idle_word_out", 32'(word_out), 32'd0);
    chk("idle_valid_count", 32'(valid_cnt), 32'd0);

    // acquire lock: 3 garbage bits then repeating comma/data/comma
    got_q.delete();
    drive_bit(1'b1, 0); drive_bit(1'b0, 0); drive_bit(1'b1, 0);
    repeat (6) for (int k = 0; k < 3; k++) drive_word(pat[k], 10, 0);
    idle(3);
    chk("acq_lock_bits", 32'(lock_bits), 32'd43);
    chk("acq_word_count", 32'(got_q.size()), 32'd14);
    if (got_q.size() >= 3) begin
      chk("acq_word0", 32'(got_q[0]), 32'h2AA);
      chk("acq_word1", 32'(got_q[1]), 32'h705);
      chk("acq_word2", 32'(got_q[2]), 32'h4FA);
    end

    // irregular bit_en at ~30% duty: same words, one pulse per ten bits
    base = got_q.size();
    vc0 = valid_cnt;
    repeat (4) for (int k = 0; k < 3; k++) drive_word(pat[k], 10, 1);
    idle(3);
    chk("gated_pulses", 32'(valid_cnt - vc0), 32'd12);
    for (int k = 0; k < 12; k++)
      if (base + k < got_q.size())
        chk("gated_word", 32'(got_q[base + k]),
            32'({(pat[k % 3] != 10'h2AA), pat[k % 3]}));
    chk("gated_locked", 32'(locked), 32'd1);

    // bit slip: drop one bit, commas continue at the new phase
    fall_cnt = 0;
    drive_word(10'h0FA, 9, 0);
    repeat (6) for (int k = 1; k < 4; k++) drive_word(pat[k % 3], 10, 0);
    idle(3);
    chk("slip_falls", 32'(fall_cnt), 32'd1);
    chk("slip_relocked", 32'(locked), 32'd1);
    chk("slip_realign_cnt", 32'(realign_cnt), CNT_EN ? 32'd1 : 32'd0);

    // reset mid-word while locked
    drive_word(10'h0FA, 5, 0);
    @(negedge clk); bit_en = 1'b0; reset = 1'b1;
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_word_out", 32'(word_out), 32'd0);
    chk("rst_realign_cnt", 32'(realign_cnt), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vc0 = valid_cnt;
    repeat (4) for (int k = 0; k < 3; k++) drive_word(pat[k], 10, 0);
    idle(3);
    chk("rst_relock_bits", 32'(lock_bits), 32'd40);
    chk("rst_no_valid_before_lock", 32'(valid_at_lock), 32'(vc0));

    // spurious comma 4 bits off-phase while in CHECK with two good commas
    do_reset();
    for (int k = 0; k < 3; k++) drive_word(pat[k], 10, 0);
    drive_word(10'h140, 4, 0);
    for (int k = 0; k < 5; k++) drive_word(pat[k % 3], 10, 0);
    idle(3);
    chk("spur_lock_bits", 32'(lock_bits), 32'd74);
    chk("spur_locked", 32'(locked), 32'd1);

    // random words, commas and occasional slips, gated; model-checked every cycle
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: w = 10'h0FA;
        1: w = 10'h305;
        default: w = 10'($urandom_range(0, 1023));
      endcase
      drive_word(w, ($urandom_range(0, 7) == 0) ? 9 : 10, 1);
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
